// File: rtl/trace_pkg.sv
// Shared constants and types for the trace frame assembler.
//   TPIU_SYNC_LO / TPIU_SYNC_HI : the two half-words of a TPIU full sync
//   FRAME_HW                    : half-words per 16-byte frame
//   HW_W                        : half-word width
//   asm_state_e                 : frame-assembler lock state
package trace_pkg;

  localparam int unsigned HW_W     = 16;
  localparam int unsigned FRAME_HW = 8;
  localparam int unsigned OFS_W    = $clog2(FRAME_HW);

  localparam logic [HW_W-1:0] TPIU_SYNC_LO = 16'hFFFF;
  localparam logic [HW_W-1:0] TPIU_SYNC_HI = 16'h7FFF;

  typedef enum logic {
    UNSYNCED = 1'b0,
    SYNCED   = 1'b1
  } asm_state_e;

endpackage

// File: rtl/tpiu_sync_detect.sv
// Hold register plus full-sync pattern compare.
// Each accepted half-word is parked for one half-word time. A parked 0xFFFF
// followed by 0x7FFF is a full sync: both words are dropped. Otherwise the
// parked word is committed and the new word takes its place.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   valid_i, data_i : incoming half-word stream
//   commit_valid_c  : combinational, a parked word is committed this cycle
//   commit_data_c   : combinational, the committed half-word
//   sync_seen_c     : combinational, full sync completes this cycle
module tpiu_sync_detect
  import trace_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [HW_W-1:0] data_i,
  output logic            commit_valid_c,
  output logic [HW_W-1:0] commit_data_c,
  output logic            sync_seen_c
);

  logic            hold_vld_q, hold_vld_d;
  logic [HW_W-1:0] hold_q, hold_d;
  logic            pair_sync;

  // Sync compare and hold register update.
  always_comb begin
    hold_vld_d     = hold_vld_q;
    hold_d         = hold_q;
    commit_valid_c = 1'b0;
    commit_data_c  = hold_q;
    sync_seen_c    = 1'b0;
    pair_sync      = hold_vld_q && (hold_q == TPIU_SYNC_LO) && (data_i == TPIU_SYNC_HI);
    if (valid_i) begin
      if (pair_sync) begin
        sync_seen_c = 1'b1;
        hold_vld_d  = 1'b0;
      end else begin
        commit_valid_c = hold_vld_q;
        hold_d         = data_i;
        hold_vld_d     = 1'b1;
      end
    end
  end

  // Hold register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: rtl/trace_frame_assembler.sv
// Locks a 16-bit TPIU half-word stream to full-sync alignment, assembles
// aligned 16-byte frames and announces each by toggling PkAvail.
// Optional feature macro: TRACE_PKT_COUNT_EN adds the PacketCount port.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   TraceDataValid  : TraceData holds a new half-word
//   TraceData       : half-word, [7:0] is the earlier byte
//   Packet          : last complete frame, half-word k at [16k+15:16k]
//   PkAvail         : toggles once per emitted frame
//   Synced          : high while locked
//   SyncLost        : one-cycle pulse when lock is dropped by timeout
//   PacketCount     : frames emitted, wraps (TRACE_PKT_COUNT_EN only)
module trace_frame_assembler
  import trace_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     TraceDataValid,
  input  logic [HW_W-1:0]          TraceData,
  output logic [FRAME_HW*HW_W-1:0] Packet,
  output logic                     PkAvail,
  output logic                     Synced,
`ifdef TRACE_PKT_COUNT_EN
  output logic                     SyncLost,
  output logic [15:0]              PacketCount
`else
  output logic                     SyncLost
`endif
);

  localparam int unsigned TMO_W = 16;

  asm_state_e                       state_q;
  logic [OFS_W-1:0]                 offset_q;
  logic [TMO_W-1:0]                 tmo_q;
  logic [FRAME_HW-1:0][HW_W-1:0]    frame_q;
  logic [FRAME_HW*HW_W-1:0]         packet_q;
  logic                             pkavail_q;
  logic                             synclost_q;

  logic                             commit_valid;
  logic [HW_W-1:0]                  commit_data;
  logic                             sync_seen;
  logic [TMO_W-1:0]                 tmo_inc;
  logic                             tmo_hit;
  logic                             emit;

  tpiu_sync_detect u_sync (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i        (TraceDataValid),
    .data_i         (TraceData),
    .commit_valid_c (commit_valid),
    .commit_data_c  (commit_data),
    .sync_seen_c    (sync_seen)
  );

  // Timeout compare; a zero SYNC_TIMEOUT never drops lock.
  always_comb begin
    tmo_inc = tmo_q + TMO_W'(1);
    tmo_hit = (SYNC_TIMEOUT != 0) && (tmo_inc == TMO_W'(SYNC_TIMEOUT));
    emit    = TraceDataValid && !sync_seen && (state_q == SYNCED) && !tmo_hit &&
              commit_valid && (offset_q == OFS_W'(FRAME_HW - 1));
  end

  // Lock state, frame slots, timeout and registered outputs.
  // Sync beats timeout on the same word; timeout beats a completing frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= UNSYNCED;
      offset_q   <= '0;
      tmo_q      <= '0;
      frame_q    <= '0;
      packet_q   <= '0;
      pkavail_q  <= 1'b0;
      synclost_q <= 1'b0;
    end else begin
      synclost_q <= 1'b0;
      if (TraceDataValid) begin
        if (sync_seen) begin
          state_q  <= SYNCED;
          offset_q <= '0;
          tmo_q    <= '0;
        end else if (state_q == SYNCED) begin
          tmo_q <= tmo_inc;
          if (tmo_hit) begin
            state_q    <= UNSYNCED;
            offset_q   <= '0;
            synclost_q <= 1'b1;
          end else if (commit_valid) begin
            frame_q[offset_q] <= commit_data;
            offset_q          <= offset_q + OFS_W'(1);
          end
        end
      end
      if (emit) begin
        packet_q  <= {commit_data, frame_q[FRAME_HW-2:0]};
        pkavail_q <= ~pkavail_q;
      end
    end
  end

`ifdef TRACE_PKT_COUNT_EN
  logic [15:0] pkt_cnt_q;

  // Emitted-frame counter, advances with each PkAvail toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
    end else if (emit) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign PacketCount = pkt_cnt_q;
`endif

  assign Packet   = packet_q;
  assign PkAvail  = pkavail_q;
  assign Synced   = (state_q == SYNCED);
  assign SyncLost = synclost_q;

endmodule

// File: tb/tb_trace_frame_assembler.sv
// Directed bench for trace_frame_assembler with SYNC_TIMEOUT=16.
module tb_trace_frame_assembler;

  logic         clk;
  logic         rst_n;
  logic         TraceDataValid;
  logic [15:0]  TraceData;
  logic [127:0] Packet;
  logic         PkAvail;
  logic         Synced;
  logic         SyncLost;
`ifdef TRACE_PKT_COUNT_EN
  logic [15:0]  PacketCount;
`endif

  int checks = 0;
  int errors = 0;
  int toggles;
  logic last_av;

  trace_frame_assembler #(.SYNC_TIMEOUT(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .TraceDataValid (TraceDataValid),
    .TraceData      (TraceData),
    .Packet         (Packet),
    .PkAvail        (PkAvail),
    .Synced         (Synced),
`ifdef TRACE_PKT_COUNT_EN
    .SyncLost       (SyncLost),
    .PacketCount    (PacketCount)
`else
    .SyncLost       (SyncLost)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One valid half-word; returns #1 after the consuming edge.
  task automatic send(input logic [15:0] w);
    @(negedge clk);
    TraceDataValid = 1'b1;
    TraceData      = w;
    @(posedge clk);
    #1;
    TraceDataValid = 1'b0;
    if (PkAvail !== last_av) toggles++;
    last_av = PkAvail;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    TraceDataValid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_av = 1'b0;
    toggles = 0;
  endtask

  task automatic lock();
    send(16'hFFFF);
    send(16'h7FFF);
  endtask

  initial begin
    rst_n = 1'b0;
    TraceDataValid = 1'b0;
    TraceData = '0;
    last_av = 1'b0;
    toggles = 0;

    // 1: reset held while valid data toggles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      TraceDataValid = ~TraceDataValid;
      TraceData = (i % 2 == 0) ? 16'hFFFF : 16'h7FFF;
      @(posedge clk);
      #1;
      chk("rst_packet", Packet, '0);
      chk("rst_pkavail", 128'(PkAvail), 128'(0));
      chk("rst_synced", 128'(Synced), 128'(0));
      chk("rst_synclost", 128'(SyncLost), 128'(0));
    end
`ifdef TRACE_PKT_COUNT_EN
    chk("rst_count", 128'(PacketCount), 128'(0));
`endif
    do_reset();

    // 2: lock and one frame
    lock();
    chk("lock_synced", 128'(Synced), 128'(1));
    for (int k = 0; k < 8; k++) send({8'(2*k+1), 8'(2*k)});
    chk("frame_not_yet", 128'(PkAvail), 128'(0));
    send(16'h1110);
    chk("frame_pkavail", 128'(PkAvail), 128'(1));
    chk("frame_packet", Packet, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
`ifdef TRACE_PKT_COUNT_EN
    chk("frame_count", 128'(PacketCount), 128'(1));
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("frame_hold", Packet, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

    // 3: no lock
    do_reset();
    for (int i = 0; i < 20; i++) send(16'h0101 * 16'(i));
    chk("nolock_toggles", 128'(toggles), 128'(0));
    chk("nolock_synced", 128'(Synced), 128'(0));

    // 4: resync mid-frame
    do_reset();
    lock();
    send(16'h1111);
    send(16'h2222);
    send(16'h3333);
    lock();
    chk("resync_synced", 128'(Synced), 128'(1));
    for (int k = 0; k < 8; k++) send(16'hA0A0 + 16'h0101 * 16'(k));
    chk("resync_no_early", 128'(toggles), 128'(0));
    send(16'hB0B0);
    chk("resync_toggles", 128'(toggles), 128'(1));
    chk("resync_packet", Packet, 128'hA7A7A6A6_A5A5A4A4_A3A3A2A2_A1A1A0A0);

    // 5: timeout after 16 words without sync
    do_reset();
    lock();
    for (int i = 1; i <= 15; i++) begin
      send(16'h0101 * 16'(i));
      if (i == 15) begin
        chk("tmo_synced_15", 128'(Synced), 128'(1));
        chk("tmo_lost_15", 128'(SyncLost), 128'(0));
      end
    end
    send(16'h1010);
    chk("tmo_synced_16", 128'(Synced), 128'(0));
    chk("tmo_lost_16", 128'(SyncLost), 128'(1));
    chk("tmo_toggles", 128'(toggles), 128'(1));
    @(posedge clk);
    #1;
    chk("tmo_lost_pulse", 128'(SyncLost), 128'(0));
    for (int i = 0; i < 10; i++) send(16'h2020 + 16'(i));
    chk("tmo_no_more", 128'(toggles), 128'(1));
    chk("tmo_stay_unsynced", 128'(Synced), 128'(0));

    // 6: data FFFF not followed by 7FFF
    do_reset();
    lock();
    for (int i = 1; i <= 7; i++) send(16'h0101 * 16'(i));
    send(16'hFFFF);
    send(16'h1234);
    chk("ffff_toggles", 128'(toggles), 128'(1));
    chk("ffff_top", 128'(Packet[127:112]), 128'(16'hFFFF));
    chk("ffff_packet", Packet, 128'hFFFF0707_06060505_04040303_02020101);
    chk("ffff_synced", 128'(Synced), 128'(1));
`ifdef TRACE_PKT_COUNT_EN
    chk("ffff_count", 128'(PacketCount), 128'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
